uni_gates_pipe: RTL and testbench

//  Parametrised, pipelined successor to the team's two-input gate block: WIDTH-bit bitwise

---
 rtl/uni_gates_pkg.sv | 24 ++
 rtl/uni_gates_stage.sv | 44 ++++
 rtl/uni_gates_pipe.sv | 136 +++++++++++++
 tb/tb_uni_gates_pipe.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uni_gates_pkg.sv
// ---------------------------------------------------------------------------
// uni_gates_pkg
// Shared definitions for the pipelined bitwise logic unit.
//   op_e        : 3-bit opcode selecting the bitwise function
//   OP_W        : opcode width
//   MAX_STAGES  : deepest supported pipeline
// ---------------------------------------------------------------------------
package uni_gates_pkg;

   localparam int OP_W       = 3;
   localparam int MAX_STAGES = 4;

   typedef enum logic [OP_W-1:0] {
      OP_NOT  = 3'd0,
      OP_OR   = 3'd1,
      OP_AND  = 3'd2,
      OP_NOR  = 3'd3,
      OP_NAND = 3'd4,
      OP_XOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_PASS = 3'd7
   } op_e;

endpackage

// File: rtl/uni_gates_stage.sv
// ---------------------------------------------------------------------------
// uni_gates_stage
// One pipeline slot: a valid bit plus a DW-bit payload, updated only when
// i_load is high. The payload is written only for valid data so an empty
// slot keeps its previous contents instead of toggling.
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_load        slot load enable
//   i_valid       incoming valid
//   i_data        incoming payload
//   o_valid       slot occupied
//   o_data        slot payload
// ---------------------------------------------------------------------------
module uni_gates_stage #(
   parameter int DW = 8
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_load,
   input  logic          i_valid,
   input  logic [DW-1:0] i_data,
   output logic          o_valid,
   output logic [DW-1:0] o_data
);

   logic          r_valid;
   logic [DW-1:0] r_data;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_load) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/uni_gates_pipe.sv
// ---------------------------------------------------------------------------
// uni_gates_pipe
// WIDTH-bit bitwise logic unit with a STAGES-deep valid/ready pipeline and a
// saturating output transfer counter.
// Optional macro: UNI_GATES_FLAGS_EN adds o_zero / o_parity, computed from the
// stage-0 result and carried alongside it through every stage.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_valid / o_ready     input handshake
//   i_in1, i_in2, i_op    operands and opcode (uni_gates_pkg::op_e)
//   o_valid / i_ready     output handshake
//   o_result              result of the oldest pipeline entry
//   i_cnt_clr             clear transfer counter (wins over increment)
//   o_op_cnt              saturating count of output transfers
//   o_zero, o_parity      result==0, XOR-reduce(result)  (UNI_GATES_FLAGS_EN)
// ---------------------------------------------------------------------------
module uni_gates_pipe
   import uni_gates_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2,
   parameter int CNT_W  = 16
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_in1,
   input  logic [WIDTH-1:0] i_in2,
   input  logic [OP_W-1:0]  i_op,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_result,
   input  logic             i_cnt_clr,
   output logic [CNT_W-1:0] o_op_cnt
`ifdef UNI_GATES_FLAGS_EN
   ,
   output logic             o_zero,
   output logic             o_parity
`endif
);

   // Depth is held to the supported range 1..MAX_STAGES.
   localparam int STG = (STAGES < 1) ? 1 : ((STAGES > MAX_STAGES) ? MAX_STAGES : STAGES);

`ifdef UNI_GATES_FLAGS_EN
   localparam int DW = WIDTH + 2;   // {zero, parity, result}
`else
   localparam int DW = WIDTH;
`endif

   logic [WIDTH-1:0] w_result;
   logic [DW-1:0]    w_payload;
   logic [STG-1:0]   w_valid;
   logic [STG-1:0]   w_load;
   logic [DW-1:0]    w_data [STG];
   logic             w_out_xfer;
   logic [CNT_W-1:0] r_cnt;

   // Opcode decode
   always_comb begin
      w_result = i_in1;
      case (op_e'(i_op))
         OP_NOT:  w_result = ~i_in1;
         OP_OR:   w_result = i_in1 | i_in2;
         OP_AND:  w_result = i_in1 & i_in2;
         OP_NOR:  w_result = ~(i_in1 | i_in2);
         OP_NAND: w_result = ~(i_in1 & i_in2);
         OP_XOR:  w_result = i_in1 ^ i_in2;
         OP_XNOR: w_result = ~(i_in1 ^ i_in2);
         OP_PASS: w_result = i_in1;
         default: w_result = i_in1;
      endcase
   end

`ifdef UNI_GATES_FLAGS_EN
   assign w_payload = {~|w_result, ^w_result, w_result};
`else
   assign w_payload = w_result;
`endif

   // Ready chain, evaluated from the output end back to stage 0 in a single
   // process: a slot may load when it is empty or when its successor loads.
   // Depends only on occupancy and i_ready, never on i_valid.
   always_comb begin
      w_load[STG-1] = ~w_valid[STG-1] | i_ready;
      for (int k = STG - 2; k >= 0; k--) begin
         w_load[k] = ~w_valid[k] | w_load[k+1];
      end
   end

   for (genvar gi = 0; gi < STG; gi++) begin : g_stage
      logic          w_vin;
      logic [DW-1:0] w_din;
      if (gi == 0) begin : g_first
         assign w_vin = i_valid;
         assign w_din = w_payload;
      end else begin : g_next
         assign w_vin = w_valid[gi-1];
         assign w_din = w_data[gi-1];
      end
      uni_gates_stage #(.DW(DW)) u_stage (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_load  (w_load[gi]),
         .i_valid (w_vin),
         .i_data  (w_din),
         .o_valid (w_valid[gi]),
         .o_data  (w_data[gi])
      );
   end

   // Both handshakes are masked during reset so nothing transfers in a cycle
   // whose in-flight contents are being discarded.
   assign o_ready    = w_load[0] & ~i_rst;
   assign o_valid    = w_valid[STG-1] & ~i_rst;
   assign o_result   = w_data[STG-1][WIDTH-1:0];
   assign w_out_xfer = o_valid & i_ready;

`ifdef UNI_GATES_FLAGS_EN
   assign o_zero   = w_data[STG-1][WIDTH+1];
   assign o_parity = w_data[STG-1][WIDTH];
`endif

   // Saturating transfer counter; clear has priority over increment.
   always_ff @(posedge i_clk) begin
      if (i_rst || i_cnt_clr) begin
         r_cnt <= '0;
      end else if (w_out_xfer && (r_cnt != {CNT_W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_op_cnt = r_cnt;

endmodule

// File: tb/tb_uni_gates_pipe.sv
module tb_uni_gates_pipe;
   logic       clk = 1'b0;
   logic       rst;
   // main DUT (WIDTH=8, STAGES=2, CNT_W=16)
   logic       valid, o_ready, o_valid, rdy, cnt_clr;
   logic [7:0] in1, in2, o_result;
   logic [2:0] op;
   logic [15:0] o_op_cnt;
   // counter DUT (CNT_W=2)
   logic       c_valid, c_o_ready, c_o_valid, c_rdy, c_clr;
   logic [7:0] c_in1, c_in2, c_result;
   logic [2:0] c_op;
   logic [1:0] c_cnt;
`ifdef UNI_GATES_FLAGS_EN
   logic       o_zero, o_parity, c_zero, c_parity;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uni_gates_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(16)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready),
      .i_in1(in1), .i_in2(in2), .i_op(op), .o_valid(o_valid), .i_ready(rdy),
      .o_result(o_result), .i_cnt_clr(cnt_clr), .o_op_cnt(o_op_cnt)
`ifdef UNI_GATES_FLAGS_EN
      , .o_zero(o_zero), .o_parity(o_parity)
`endif
   );

   uni_gates_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(2)) dut_c (
      .i_clk(clk), .i_rst(rst), .i_valid(c_valid), .o_ready(c_o_ready),
      .i_in1(c_in1), .i_in2(c_in2), .i_op(c_op), .o_valid(c_o_valid), .i_ready(c_rdy),
      .o_result(c_result), .i_cnt_clr(c_clr), .o_op_cnt(c_cnt)
`ifdef UNI_GATES_FLAGS_EN
      , .o_zero(c_zero), .o_parity(c_parity)
`endif
   );

   // Advance to just after the next rising edge.
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; valid = 1'b0; rdy = 1'b1; cnt_clr = 1'b0;
      in1 = '0; in2 = '0; op = '0;
      c_valid = 1'b0; c_rdy = 1'b1; c_clr = 1'b0; c_in1 = '0; c_in2 = '0; c_op = '0;
      repeat (3) cycle();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_o_valid got=%b exp=0", o_valid); end
      checks++; if (o_result !== 8'h00) begin errors++; $display("FAIL reset_o_result got=%h exp=00", o_result); end
      checks++; if (o_op_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", o_op_cnt); end
      checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_o_ready_in_reset got=%b exp=0", o_ready); end
      rst = 1'b0;
      #1;
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_o_ready_after got=%b exp=1", o_ready); end
      $display("reset: o_valid=%b o_result=%h cnt=%0d o_ready=%b", o_valid, o_result, o_op_cnt, o_ready);
   endtask

   task automatic test_ops();
      logic [7:0] exp_t [8];
      exp_t = '{8'h5A, 8'hAF, 8'h05, 8'h50, 8'hFA, 8'hAA, 8'h55, 8'hA5};
      rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in1 = 8'hA5; in2 = 8'h0F; op = 3'(k); valid = 1'b1;
         cycle();
         valid = 1'b0;
         checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL ops_latency_early op=%0d got=%b exp=0", k, o_valid); end
         cycle();
         checks++;
         if (o_valid !== 1'b1 || o_result !== exp_t[k]) begin
            errors++; $display("FAIL ops_result op=%0d got valid=%b res=%h exp valid=1 res=%h", k, o_valid, o_result, exp_t[k]);
         end
         $display("op %0d: A=a5 B=0f result=%h expected=%h", k, o_result, exp_t[k]);
      end
      cycle();
      checks++; if (o_op_cnt !== 16'd8) begin errors++; $display("FAIL ops_cnt got=%0d exp=8", o_op_cnt); end
      cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
      checks++; if (o_op_cnt !== 16'd0) begin errors++; $display("FAIL cnt_clear got=%0d exp=0", o_op_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] got [$];
      int         at [$];
      bit         ready_low = 0;
      rdy = 1'b1; op = 3'd5; in2 = 8'h30;
      for (int c = 0; c < 14; c++) begin
         valid = (c < 8);
         in1 = 8'(c);
         #1;
         if (c < 8 && o_ready !== 1'b1) ready_low = 1;
         if (o_valid === 1'b1) begin got.push_back(o_result); at.push_back(c); end
         cycle();
      end
      valid = 1'b0;
      checks++; if (got.size() != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", got.size()); end
      for (int i = 0; i < 8 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== (8'(i) ^ 8'h30)) begin errors++; $display("FAIL b2b_data idx=%0d got=%h exp=%h", i, got[i], 8'(i) ^ 8'h30); end
         $display("b2b out %0d: cycle=%0d result=%h", i, at[i], got[i]);
      end
      checks++;
      if (got.size() == 8 && (at[0] != 2 || at[7] != 9)) begin
         errors++; $display("FAIL b2b_cycles got first=%0d last=%0d exp first=2 last=9", at[0], at[7]);
      end
      checks++; if (ready_low) begin errors++; $display("FAIL b2b_ready got=low exp=always high"); end
      checks++; if (o_op_cnt !== 16'd8) begin errors++; $display("FAIL b2b_cnt got=%0d exp=8", o_op_cnt); end
   endtask

   task automatic test_backpressure();
      logic [7:0] expq [$];
      logic [7:0] held = '0;
      bit         held_ok = 0;
      int         d = 0, stall_acc = 0, n_out = 0, n_acc = 0;
      op = 3'd7; in2 = 8'h00;
      for (int c = 0; c < 20; c++) begin
         rdy = (c >= 5);
         valid = (d < 6);
         in1 = 8'h40 + 8'(d);
         #1;
         if (o_valid === 1'b1 && rdy) begin
            n_out++;
            checks++;
            if (expq.size() == 0) begin
               errors++; $display("FAIL bp_dup got=%h exp=none", o_result);
            end else begin
               if (o_result !== expq[0]) begin errors++; $display("FAIL bp_data got=%h exp=%h", o_result, expq[0]); end
               $display("bp out: cycle=%0d result=%h expected=%h", c, o_result, expq[0]);
               void'(expq.pop_front());
            end
         end else if (o_valid === 1'b1) begin
            if (held_ok) begin
               checks++;
               if (o_result !== held) begin errors++; $display("FAIL bp_hold got=%h exp=%h", o_result, held); end
            end
            held = o_result; held_ok = 1;
         end
         if (valid && o_ready === 1'b1) begin
            expq.push_back(in1); d++; n_acc++;
            if (!rdy) stall_acc++;
         end
         cycle();
      end
      valid = 1'b0; rdy = 1'b1;
      checks++; if (stall_acc != 2) begin errors++; $display("FAIL bp_stall_accepts got=%0d exp=2", stall_acc); end
      checks++; if (n_out != 6 || n_acc != 6) begin errors++; $display("FAIL bp_loss got out=%0d acc=%0d exp=6", n_out, n_acc); end
   endtask

   task automatic test_counter_sat();
      int xfers = 0;
      bit seen = 0;
      c_rdy = 1'b1; c_op = 3'd7; c_in1 = 8'h11; c_in2 = 8'h00;
      for (int c = 0; c < 9; c++) begin
         c_valid = (c < 5);
         #1;
         if (c_o_valid === 1'b1) xfers++;
         cycle();
      end
      c_valid = 1'b0;
      checks++; if (xfers != 5) begin errors++; $display("FAIL cnt_xfers got=%0d exp=5", xfers); end
      checks++; if (c_cnt !== 2'd3) begin errors++; $display("FAIL cnt_saturate got=%0d exp=3", c_cnt); end
      $display("cnt: transfers=%0d o_op_cnt=%0d", xfers, c_cnt);
      c_valid = 1'b1;
      cycle();
      c_valid = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         if (c_o_valid === 1'b1) seen = 1; else cycle();
      end
      checks++;
      if (!seen) begin
         errors++; $display("FAIL cnt_clr_wait got=timeout exp=o_valid");
      end else begin
         c_clr = 1'b1;
         cycle();
         c_clr = 1'b0;
         if (c_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clr_wins got=%0d exp=0", c_cnt); end
      end
      $display("cnt: clear with transfer o_op_cnt=%0d", c_cnt);
   endtask

   task automatic test_reset_midflight();
      bit late = 0;
      rdy = 1'b1; op = 3'd1; in1 = 8'h12; in2 = 8'h21; valid = 1'b1;
      cycle();
      in1 = 8'h34;
      cycle();
      valid = 1'b0;
      #1;
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL mid_inflight got=%b exp=1", o_valid); end
      rst = 1'b1;
      cycle();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_o_valid got=%b exp=0", o_valid); end
      checks++; if (o_op_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt got=%0d exp=0", o_op_cnt); end
      rst = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (o_valid !== 1'b0) late = 1;
         cycle();
      end
      checks++; if (late) begin errors++; $display("FAIL mid_late_output got=valid exp=none"); end
      checks++; if (o_op_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt_after got=%0d exp=0", o_op_cnt); end
      $display("midflight reset: o_valid=%b cnt=%0d", o_valid, o_op_cnt);
   endtask

`ifdef UNI_GATES_FLAGS_EN
   task automatic test_flags();
      rdy = 1'b1; valid = 1'b1; op = 3'd2; in1 = 8'hF0; in2 = 8'h0F;
      cycle();
      op = 3'd5; in1 = 8'h01; in2 = 8'h00;
      cycle();
      valid = 1'b0;
      checks++; if (o_valid !== 1'b1 || o_zero !== 1'b1 || o_parity !== 1'b0) begin
         errors++; $display("FAIL flags_and got v=%b z=%b p=%b exp v=1 z=1 p=0", o_valid, o_zero, o_parity); end
      cycle();
      checks++; if (o_valid !== 1'b1 || o_zero !== 1'b0 || o_parity !== 1'b1) begin
         errors++; $display("FAIL flags_xor got v=%b z=%b p=%b exp v=1 z=0 p=1", o_valid, o_zero, o_parity); end
      cycle();
      $display("flags: checked AND and XOR cases");
   endtask
`endif

   initial begin
      test_reset();
      test_ops();
      test_back_to_back();
      test_backpressure();
      test_counter_sat();
      test_reset_midflight();
`ifdef UNI_GATES_FLAGS_EN
      test_flags();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
